// File: rtl/membus_arbiter.sv
// rtl/membus_arbiter.sv - two-master arbiter onto a single-strobe memory bus
`timescale 1ns/1ps

module membus_arbiter #(
  parameter int READ_LATENCY   = 2,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       m0_read_req_i,
  input  logic       m0_write_req_i,
  input  logic [6:0] m0_addr_i,
  input  logic [7:0] m0_data_i,
  output logic       m0_ack_o,
  output logic [7:0] m0_data_o,
  input  logic       m1_read_req_i,
  input  logic       m1_write_req_i,
  input  logic [6:0] m1_addr_i,
  input  logic [7:0] m1_data_i,
  output logic       m1_ack_o,
  output logic [7:0] m1_data_o,
  output logic       membus_read_req_o,
  output logic       membus_write_req_o,
  output logic [6:0] membus_addr_o,
  output logic [7:0] membus_data_o,
  input  logic [7:0] membus_data_i,
  output logic       proto_err_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  // WAIT spends READ_LATENCY-1 cycles; the counter's terminal value is one less than that.
  localparam logic [2:0] WAIT_LAST = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;

  state_t     state_q, state_d;
  logic       win_q;
  logic       is_write_q;
  logic [6:0] addr_q;
  logic [7:0] wdata_q;
  logic [2:0] cnt_q;
  logic       last_grant_q;
  logic [7:0] m0_rdata_q, m1_rdata_q;
  logic       proto_err_q;

  logic pend0, pend1, any_pend, grant1, capture_rd;

  assign pend0    = m0_read_req_i | m0_write_req_i;
  assign pend1    = m1_read_req_i | m1_write_req_i;
  assign any_pend = pend0 | pend1;

  // Round-robin: on a tie the master that did not win last time takes the bus.
  always_comb begin
    grant1 = 1'b0;
    if (FIXED_PRIORITY != 0) begin
      grant1 = pend1 & ~pend0;
    end else begin
      grant1 = pend1 & (~pend0 | ~last_grant_q);
    end
  end

  assign capture_rd = !is_write_q && (state_q != DONE) && (state_d == DONE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_pend) state_d = ISSUE;
      ISSUE:   state_d = (is_write_q || READ_LATENCY <= 1) ? DONE : WAIT;
      WAIT:    if (cnt_q == WAIT_LAST) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      win_q        <= 1'b0;
      is_write_q   <= 1'b0;
      addr_q       <= 7'd0;
      wdata_q      <= 8'd0;
      cnt_q        <= 3'd0;
      last_grant_q <= 1'b1;
      m0_rdata_q   <= 8'd0;
      m1_rdata_q   <= 8'd0;
      proto_err_q  <= 1'b0;
    end else begin
      // Read+write together is serviced as a write.
      if (state_q == IDLE && any_pend) begin
        win_q        <= grant1;
        last_grant_q <= grant1;
        is_write_q   <= grant1 ? m1_write_req_i : m0_write_req_i;
        addr_q       <= grant1 ? m1_addr_i : m0_addr_i;
        wdata_q      <= grant1 ? m1_data_i : m0_data_i;
      end
      if (state_q == ISSUE) begin
        cnt_q <= 3'd0;
      end else if (state_q == WAIT) begin
        cnt_q <= cnt_q + 3'd1;
      end
      if (capture_rd) begin
        if (win_q) begin
          m1_rdata_q <= membus_data_i;
        end else begin
          m0_rdata_q <= membus_data_i;
        end
      end
      proto_err_q <= proto_err_q | (m0_read_req_i & m0_write_req_i)
                                 | (m1_read_req_i & m1_write_req_i);
    end
  end

  always_comb begin
    membus_read_req_o  = 1'b0;
    membus_write_req_o = 1'b0;
    membus_addr_o      = 7'd0;
    membus_data_o      = 8'd0;
    m0_ack_o           = 1'b0;
    m1_ack_o           = 1'b0;
    case (state_q)
      ISSUE: begin
        membus_read_req_o  = ~is_write_q;
        membus_write_req_o = is_write_q;
        membus_addr_o      = addr_q;
        membus_data_o      = wdata_q;
      end
      DONE: begin
        m0_ack_o = ~win_q;
        m1_ack_o = win_q;
      end
      default: ;
    endcase
  end

  assign m0_data_o   = m0_rdata_q;
  assign m1_data_o   = m1_rdata_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_membus_arbiter.sv
// tb/tb_membus_arbiter.sv - self-checking bench for membus_arbiter
`timescale 1ns/1ps

module tb_membus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       m0_rd, m0_wr, m1_rd, m1_wr;
  logic [6:0] m0_addr, m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic [7:0] slave_rdata, bus_rdata;
  logic       rd_d = 1'b0;

  logic       rr_m0_ack, rr_m1_ack, rr_rd, rr_wr, rr_perr;
  logic [7:0] rr_m0_data, rr_m1_data, rr_wd;
  logic [6:0] rr_addr;
  logic       fp_m0_ack, fp_m1_ack, fp_rd, fp_wr, fp_perr;
  logic [7:0] fp_m0_data, fp_m1_data, fp_wd;
  logic [6:0] fp_addr;

  membus_arbiter #(.READ_LATENCY(2), .FIXED_PRIORITY(0)) dut_rr (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_read_req_i(m0_rd), .m0_write_req_i(m0_wr), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
    .m0_ack_o(rr_m0_ack), .m0_data_o(rr_m0_data),
    .m1_read_req_i(m1_rd), .m1_write_req_i(m1_wr), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
    .m1_ack_o(rr_m1_ack), .m1_data_o(rr_m1_data),
    .membus_read_req_o(rr_rd), .membus_write_req_o(rr_wr), .membus_addr_o(rr_addr),
    .membus_data_o(rr_wd), .membus_data_i(bus_rdata), .proto_err_o(rr_perr)
  );

  membus_arbiter #(.READ_LATENCY(2), .FIXED_PRIORITY(1)) dut_fp (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_read_req_i(m0_rd), .m0_write_req_i(m0_wr), .m0_addr_i(m0_addr), .m0_data_i(m0_wdata),
    .m0_ack_o(fp_m0_ack), .m0_data_o(fp_m0_data),
    .m1_read_req_i(m1_rd), .m1_write_req_i(m1_wr), .m1_addr_i(m1_addr), .m1_data_i(m1_wdata),
    .m1_ack_o(fp_m1_ack), .m1_data_o(fp_m1_data),
    .membus_read_req_o(fp_rd), .membus_write_req_o(fp_wr), .membus_addr_o(fp_addr),
    .membus_data_o(fp_wd), .membus_data_i(bus_rdata), .proto_err_o(fp_perr)
  );

  // Slave: read data is valid only in the cycle after the read strobe (READ_LATENCY=2).
  always @(posedge clk) rd_d <= rr_rd | fp_rd;
  assign bus_rdata = rd_d ? slave_rdata : 8'hEE;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit         m;
    logic [7:0] data;
  } exp_t;
  exp_t sb_q[$];
  logic [7:0] exp_d0 = 8'd0;
  logic [7:0] exp_d1 = 8'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ack_onehot", 32'(rr_m0_ack & rr_m1_ack), 32'd0);
      if (rr_m0_ack || rr_m1_ack) begin
        chk("sb_ack_expected", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp_t e;
          e = sb_q.pop_front();
          chk("sb_master", 32'(rr_m1_ack), 32'(e.m));
          chk("sb_data_o", 32'(e.m ? rr_m1_data : rr_m0_data), 32'(e.data));
        end
      end
    end
  end

  typedef struct {
    bit         m;
    bit         rd;
    bit         wr;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    bit         drop;
    int         lat;
  } vec_t;
  vec_t vecs[6];

  task automatic set_req(input bit m, input bit rd, input bit wr);
    if (m) begin m1_rd = rd; m1_wr = wr; end
    else   begin m0_rd = rd; m0_wr = wr; end
  endtask

  // Called on a negedge while the arbiter is idle; returns on the ack negedge.
  task automatic run_vec(input vec_t v);
    bit got = 1'b0;
    int strobes = 0;
    slave_rdata = v.rdata;
    if (v.m) begin m1_addr = v.addr; m1_wdata = v.wdata; end
    else     begin m0_addr = v.addr; m0_wdata = v.wdata; end
    set_req(v.m, v.rd, v.wr);
    if (!v.wr) begin
      if (v.m) exp_d1 = v.rdata; else exp_d0 = v.rdata;
    end
    sb_q.push_back('{m: v.m, data: (v.m ? exp_d1 : exp_d0)});
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (rr_rd || rr_wr) begin
        strobes++;
        chk("strobe_dir", 32'(rr_wr), 32'(v.wr));
        chk("strobe_excl", 32'(rr_rd & rr_wr), 32'd0);
        chk("bus_addr", 32'(rr_addr), 32'(v.addr));
        if (v.wr) chk("bus_wdata", 32'(rr_wd), 32'(v.wdata));
      end else begin
        chk("bus_idle_zero", 32'({rr_addr, rr_wd}), 32'd0);
      end
      if (v.drop && k == 1) set_req(v.m, 1'b0, 1'b0);
      if (v.m ? rr_m1_ack : rr_m0_ack) begin
        got = 1'b1;
        chk("ack_latency", 32'(k + 1), 32'(v.lat));
        chk("strobe_count", 32'(strobes), 32'd1);
        set_req(v.m, 1'b0, 1'b0);
      end
    end
    if (!got) chk("ack_timeout", 32'(got), 32'd1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m0_rd = 0; m0_wr = 0; m1_rd = 0; m1_wr = 0;
    sb_q.delete();
    exp_d0 = 8'd0;
    exp_d1 = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  bit rr_g[4];
  bit fp_g[4];
  int n_rr, n_fp;
  vec_t pv;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    m0_rd = 0; m0_wr = 0; m1_rd = 0; m1_wr = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    slave_rdata = 0;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 7'h10, 8'h5A, 8'h00, 1'b0, 3};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 7'h21, 8'h00, 8'hC3, 1'b0, 4};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 7'h7F, 8'h00, 8'h81, 1'b0, 4};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 7'h00, 8'hFF, 8'h12, 1'b0, 3};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 7'h45, 8'h3C, 8'h00, 1'b1, 3};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 7'h0A, 8'h00, 8'h5E, 1'b1, 4};

    repeat (2) @(negedge clk);
    chk("rst_bus", 32'({rr_rd, rr_wr, rr_addr, rr_wd}), 32'd0);
    chk("rst_ack", 32'({rr_m0_ack, rr_m1_ack, fp_m0_ack, fp_m1_ack}), 32'd0);
    chk("rst_data_o", 32'({rr_m0_data, rr_m1_data}), 32'd0);
    chk("rst_perr", 32'({rr_perr, fp_perr}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      run_vec(vecs[i]);
    end

    // Both masters hold write requests continuously.
    apply_reset();
    @(negedge clk);
    m0_addr = 7'h01; m0_wdata = 8'h11; m1_addr = 7'h02; m1_wdata = 8'h22;
    m0_wr = 1'b1; m1_wr = 1'b1;
    for (int i = 0; i < 4; i++) sb_q.push_back('{m: 1'(i % 2), data: 8'h00});
    n_rr = 0; n_fp = 0;
    for (int k = 0; k < 40 && n_rr < 4; k++) begin
      @(negedge clk);
      if (rr_m0_ack || rr_m1_ack) begin rr_g[n_rr] = rr_m1_ack; n_rr++; end
      if (fp_m0_ack || fp_m1_ack) begin
        if (n_fp < 4) fp_g[n_fp] = fp_m1_ack;
        n_fp++;
      end
    end
    m0_wr = 1'b0; m1_wr = 1'b0;
    chk("rr_grant_count", 32'(n_rr), 32'd4);
    chk("fp_grant_count", 32'(n_fp), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_grant%0d", i), 32'(rr_g[i]), 32'(i % 2));
      chk($sformatf("fp_grant%0d", i), 32'(fp_g[i]), 32'd0);
    end

    // Read+write together from master 0.
    @(negedge clk);
    chk("perr_before", 32'(rr_perr), 32'd0);
    pv = '{1'b0, 1'b1, 1'b1, 7'h33, 8'h44, 8'h99, 1'b0, 3};
    run_vec(pv);
    chk("perr_set_rr", 32'(rr_perr), 32'd1);
    chk("perr_set_fp", 32'(fp_perr), 32'd1);
    @(negedge clk);
    pv = '{1'b1, 1'b1, 1'b0, 7'h22, 8'h00, 8'h66, 1'b0, 4};
    run_vec(pv);
    chk("perr_sticky", 32'(rr_perr), 32'd1);

    // Reset pulse while the read is in WAIT.
    @(negedge clk);
    slave_rdata = 8'h77; m1_addr = 7'h21; m1_rd = 1'b1;
    @(negedge clk);
    chk("abort_issue_strobe", 32'(rr_rd), 32'd1);
    @(negedge clk);
    chk("abort_wait_quiet", 32'({rr_rd, rr_wr, rr_m1_ack}), 32'd0);
    rst_n = 1'b0;
    m1_rd = 1'b0;
    #1;
    chk("abort_bus_zero", 32'({rr_rd, rr_wr, rr_addr, rr_wd}), 32'd0);
    chk("abort_misc_zero", 32'({rr_m0_ack, rr_m1_ack, rr_m0_data, rr_m1_data, rr_perr}), 32'd0);
    sb_q.delete();
    exp_d0 = 8'd0;
    exp_d1 = 8'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_ack", 32'({rr_m0_ack, rr_m1_ack}), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    pv = '{1'b1, 1'b1, 1'b0, 7'h21, 8'h00, 8'hC3, 1'b0, 4};
    run_vec(pv);
    chk("after_abort_data", 32'(rr_m1_data), 32'h0C3);
    chk("after_abort_perr", 32'(rr_perr), 32'd0);
    repeat (2) @(negedge clk);
    chk("data_o_held", 32'(rr_m1_data), 32'h0C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
